// File: rtl/data_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : data_pipe
//  Description : Parameterised ready/valid register pipeline with bubble
//                collapse, synchronous flush and an occupancy counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_pipe #(
   parameter int               WIDTH      = 8,
   parameter int               DEPTH      = 2,
   parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_flush,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic [WIDTH-1:0]             i_data,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [WIDTH-1:0]             o_data,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int c_cnt_w = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]   r_v;
   logic [WIDTH-1:0]   r_d [DEPTH];
   logic [c_cnt_w-1:0] r_count;

   logic [DEPTH-1:0]   w_load;
   logic [DEPTH-1:0]   w_in_v;
   logic [WIDTH-1:0]   w_in_d [DEPTH];
   logic               w_full_above;
   logic               w_push;
   logic               w_pop;

   // Stage k loads when the output side accepts, or when any stage from k to
   // the output is empty; computed from registers only, so no comb chain.
   always_comb begin
      w_full_above = 1'b1;
      w_load       = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         w_full_above = w_full_above & r_v[k];
         w_load[k]    = i_ready | ~w_full_above;
      end
   end

   // Source of each stage: upstream port for stage 0, previous stage otherwise.
   always_comb begin
      w_in_v    = '0;
      w_in_v[0] = i_valid;
      w_in_d[0] = i_data;
      for (int k = 1; k < DEPTH; k++) begin
         w_in_v[k] = r_v[k-1];
         w_in_d[k] = r_d[k-1];
      end
   end

   assign o_ready = w_load[0] & ~i_flush & ~i_reset;
   assign w_push  = i_valid & o_ready;
   assign w_pop   = r_v[DEPTH-1] & i_ready;

   // Stage registers: reset wins, flush drops valids but keeps data untouched.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_v <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            r_d[k] <= RESET_DATA;
         end
      end else if (i_flush) begin
         r_v <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (w_load[k]) begin
               r_v[k] <= w_in_v[k];
               r_d[k] <= w_in_d[k];
            end
         end
      end
   end

   // Occupancy tracks pushes and pops so it always equals the set valid bits.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
      end
   end

   assign o_valid = r_v[DEPTH-1];
   assign o_data  = r_d[DEPTH-1];
   assign o_count = r_count;

endmodule
`default_nettype wire

// File: doc/data_pipe.md
DATA_PIPE -- requirements
Module: data_pipe

Interface
REQ-001 The module SHALL provide parameter WIDTH, default 8, giving the data width in bits (legal range 1..256).
REQ-002 The module SHALL provide parameter DEPTH, default 2, giving the number of register stages (legal range 1..16).
REQ-003 The module SHALL provide parameter RESET_DATA, default 0, a WIDTH-bit value loaded into every stage data register on reset.
REQ-004 The module SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port i_reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 The module SHALL have port i_flush, input, 1 bit: synchronous discard of all held data.
REQ-007 The module SHALL have port i_valid, input, 1 bit: upstream data valid.
REQ-008 The module SHALL have port o_ready, output, 1 bit: block can accept upstream data this cycle.
REQ-009 The module SHALL have port i_data, input, WIDTH bits: upstream data.
REQ-010 The module SHALL have port o_valid, output, 1 bit: downstream data valid.
REQ-011 The module SHALL have port i_ready, input, 1 bit: downstream can accept data.
REQ-012 The module SHALL have port o_data, output, WIDTH bits: downstream data.
REQ-013 The module SHALL have port o_count, output, $clog2(DEPTH+1) bits: number of occupied stages.

Function
REQ-014 Stages SHALL be numbered 0 (input side) to DEPTH-1 (output side); each stage SHALL hold a valid bit v[k] and a data register d[k].
REQ-015 Stage DEPTH-1 SHALL advance when i_ready=1; stage k<DEPTH-1 SHALL advance when stage k+1 loads.
REQ-016 Stage k SHALL load when v[k]=0 or stage k advances; on load, stage 0 SHALL take i_data/i_valid and stage k>0 SHALL take d[k-1]/v[k-1].
REQ-017 o_ready SHALL equal the stage-0 load condition and i_flush=0, combinationally; bubbles SHALL collapse so that any empty stage makes o_ready=1.
REQ-018 An upstream transfer SHALL occur on a rising edge with i_valid=1 and o_ready=1; a downstream transfer SHALL occur with o_valid=1 and i_ready=1.
REQ-019 o_valid SHALL equal v[DEPTH-1] and o_data SHALL equal d[DEPTH-1], both driven directly from registers.
REQ-020 Latency: a word accepted into an empty pipe SHALL appear on o_data with o_valid=1 exactly DEPTH cycles after its accepting edge.
REQ-021 Throughput SHALL be one word per cycle when i_valid=1 and i_ready=1 continuously.
REQ-022 While o_valid=1 and i_ready=0, o_data and o_valid SHALL remain stable.
REQ-023 A data register SHALL change only when its stage loads; data SHALL never be duplicated, dropped, or reordered except by flush or reset.
REQ-024 Full with i_ready=0 (o_count=DEPTH): o_ready SHALL be 0. Full with i_ready=1: o_ready SHALL be 1, allowing simultaneous in/out with the count unchanged.
REQ-025 o_count SHALL be registered and SHALL equal the number of set v[k] after each edge: +1 on input-only, -1 on output-only, unchanged on both or neither.
REQ-026 i_flush=1 SHALL clear all v[k] and o_count at the next edge, SHALL force o_ready=0 for that cycle, and SHALL leave data registers unchanged; a downstream transfer in the flush cycle SHALL still be counted as completed by the consumer.
REQ-027 With DEPTH=1, the block SHALL behave as a single registered ready/valid stage with o_ready = !v[0] | i_ready.

Reset
REQ-028 While i_reset=1 at a rising edge, all v[k] SHALL become 0, all d[k] SHALL become RESET_DATA, and o_count SHALL become 0.
REQ-029 After reset: o_valid=0, o_data=RESET_DATA, o_count=0, and o_ready=1 unless i_flush=1.
REQ-030 i_reset SHALL take priority over i_flush and any transfer; reset mid-stream SHALL discard all in-flight words.
REQ-031 o_ready SHALL be 0 while i_reset=1.

Verification (WIDTH=8, DEPTH=3)
REQ-032 Reset, then single word 0xA5 with i_ready=1 -> o_valid=1 and o_data=0xA5 exactly 3 cycles after acceptance, o_count sequence 1,1,1,0.
REQ-033 Stream 0x01..0x10 with i_valid=1 and i_ready=1 -> outputs 0x01..0x10 in order, one per cycle, no gaps after the initial 3-cycle latency.
REQ-034 i_ready=0 while pushing 0x11,0x22,0x33,0x44 -> first three accepted, o_count=3, o_ready=0, 0x44 held upstream; raise i_ready -> 0x11,0x22,0x33,0x44 delivered in order.
REQ-035 Full pipe, i_valid=1, i_ready=1 in the same cycle -> o_ready=1, one word in and one out, o_count stays 3.
REQ-036 Pipe holding 2 words, assert i_flush for one cycle with i_valid=1 -> o_ready=0 that cycle, o_valid=0 and o_count=0 next cycle, flushed words never appear.
REQ-037 Assert i_reset mid-stream with o_count=2 -> next cycle o_valid=0, o_data=0x00, o_count=0; no pre-reset word is emitted afterward.
